serial_tx: RTL and testbench

//   Transmit end of the single-wire serial link whose receive side is a chain of
//   dff capture stages. Accepts a parallel word on a valid/ready handshake and

---
 rtl/serial_tx_if.sv | 21 ++
 rtl/serial_tx.sv | 127 ++++++++++++
 tb/tb_serial_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/serial_tx_if.sv
// Handshake and serial-line bundle between a word producer and serial_tx.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             ready;
  logic             sdo;
  logic             busy;
  logic             done;

  modport master (
    output data_in, valid,
    input  ready, sdo, busy, done
  );

  modport slave (
    input  data_in, valid,
    output ready, sdo, busy, done
  );
endinterface

// File: rtl/serial_tx.sv
// Serial transmitter: accepts a word on valid/ready and sends it on sdo as a
// frame of one start bit (0), WIDTH data bits LSB first, and one stop bit (1).
// Each bit is held for CLKS_PER_BIT cycles. The line idles high, and every
// output is registered.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_tx_if.slave  tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic             sdo_r, sdo_nxt;
  logic             ready_r, ready_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;

  // Next-state and next-output logic; the bit about to go out is always sh[0].
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    sdo_nxt   = sdo_r;
    ready_nxt = ready_r;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (tx.valid) begin
          state_nxt = START;
          sh_nxt    = tx.data_in;
          cnt_nxt   = '0;
          sdo_nxt   = 1'b0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (cnt == CNT_MAX) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          sdo_nxt   = sh[0];
          sh_nxt    = sh >> 1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = '0;
          if (idx == IDX_MAX) begin
            state_nxt = STOP;
            idx_nxt   = '0;
            sdo_nxt   = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
            sdo_nxt = sh[0];
            sh_nxt  = sh >> 1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sdo_nxt   = 1'b1;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        sdo_nxt   = 1'b1;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, shift register and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      sdo_r   <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      sh      <= sh_nxt;
      sdo_r   <= sdo_nxt;
      ready_r <= ready_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
    end
  end

  assign tx.sdo   = sdo_r;
  assign tx.ready = ready_r;
  assign tx.busy  = busy_r;
  assign tx.done  = done_r;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed and random frames compared cycle by cycle
// against a frame-level model of the expected line waveform.
module tb_serial_tx;
  localparam int W   = 8;
  localparam int CPB = 2;
  localparam int LEN = (W + 2) * CPB;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W)) ifa ();
  serial_tx_if #(.WIDTH(1)) ifb ();

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_a (.clk(clk), .rst_n(rst_n), .tx(ifa));
  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1))   u_b (.clk(clk), .rst_n(rst_n), .tx(ifb));

  // Line level k cycles after the accept edge: start bit, data bits, stop, idle.
  function automatic logic m_sdo(input int k, input int w, input int cpb, input logic [7:0] word);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= w) return word[b-1];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int k, input logic [7:0] w);
    logic rdy;
    rdy = (k >= LEN);
    chk($sformatf("%s.sdo[%0d]", tag, k),   ifa.sdo,   m_sdo(k, W, CPB, w));
    chk($sformatf("%s.ready[%0d]", tag, k), ifa.ready, rdy);
    chk($sformatf("%s.busy[%0d]", tag, k),  ifa.busy,  ~rdy);
    chk($sformatf("%s.done[%0d]", tag, k),  ifa.done,  (k == LEN));
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".sdo"},   ifa.sdo,   1'b1);
    chk({tag, ".ready"}, ifa.ready, 1'b1);
    chk({tag, ".busy"},  ifa.busy,  1'b0);
    chk({tag, ".done"},  ifa.done,  1'b0);
  endtask

  task automatic idle_a(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_idle_a(tag);
    end
  endtask

  // Caller has placed word and valid=1 at a negedge; the next edge is E0.
  task automatic run_frame(input logic [7:0] w, input bit keep, input bit interfere,
                           input int rst_at, input string tag);
    @(posedge clk);
    for (int k = 0; k <= LEN; k++) begin
      @(negedge clk);
      chk_a(tag, k, w);
      if (k == 0 && !keep) ifa.valid = 1'b0;
      if (interfere) begin
        if (k >= 1 && k < LEN - 1) begin
          ifa.data_in = 8'hC3;
          ifa.valid   = k[0];
        end else begin
          ifa.valid = 1'b0;
        end
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle_a({tag, ".abort"});
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    logic       b;

    // Reset with valid asserted: nothing may be accepted.
    rst_n       = 1'b0;
    ifa.valid   = 1'b1;
    ifa.data_in = 8'hAA;
    ifb.valid   = 1'b0;
    ifb.data_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_idle_a("rst");
      chk("rstB.sdo", ifb.sdo, 1'b1);
      chk("rstB.ready", ifb.ready, 1'b1);
    end
    ifa.valid = 1'b0;
    rst_n     = 1'b1;
    idle_a(2, "post_rst");

    // Single frame.
    ifa.data_in = 8'hA5;
    ifa.valid   = 1'b1;
    run_frame(8'hA5, 1'b0, 1'b0, -1, "a5");
    idle_a(2, "a5_idle");

    // Back-to-back with valid held high.
    ifa.data_in = 8'hFF;
    ifa.valid   = 1'b1;
    run_frame(8'hFF, 1'b1, 1'b0, -1, "ff");
    ifa.data_in = 8'h00;
    run_frame(8'h00, 1'b0, 1'b0, -1, "00");
    idle_a(2, "b2b_idle");

    // Mid-frame data and valid interference.
    ifa.data_in = 8'h3C;
    ifa.valid   = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b1, -1, "3c");
    idle_a(3, "3c_idle");

    // Reset during data bit 4, then a clean frame.
    ifa.data_in = 8'h5A;
    ifa.valid   = 1'b1;
    run_frame(8'h5A, 1'b0, 1'b0, 10, "abort");
    idle_a(3, "abort_idle");
    ifa.data_in = 8'h81;
    ifa.valid   = 1'b1;
    run_frame(8'h81, 1'b0, 1'b0, -1, "81");

    // Random words with random idle gaps.
    for (int n = 0; n < 8; n++) begin
      w           = 8'($urandom);
      ifa.data_in = w;
      ifa.valid   = 1'b1;
      run_frame(w, 1'b0, 1'b0, -1, $sformatf("rnd%0d", n));
      idle_a(int'($urandom_range(0, 3)), "rnd_idle");
    end

    // One-bit frames at one cycle per bit.
    for (int n = 0; n < 2; n++) begin
      b           = n[0];
      ifb.data_in = b;
      ifb.valid   = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 3; k++) begin
        @(negedge clk);
        if (k == 0) ifb.valid = 1'b0;
        chk($sformatf("w1b%0d.sdo[%0d]", n, k),   ifb.sdo,   m_sdo(k, 1, 1, {7'd0, b}));
        chk($sformatf("w1b%0d.ready[%0d]", n, k), ifb.ready, (k >= 3));
        chk($sformatf("w1b%0d.busy[%0d]", n, k),  ifb.busy,  (k < 3));
        chk($sformatf("w1b%0d.done[%0d]", n, k),  ifb.done,  (k == 3));
      end
      @(negedge clk);
      chk($sformatf("w1b%0d.done_clr", n), ifb.done, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
